slave_rx: RTL and testbench

Double-buffered serial receiver at the far end of the single-wire link driven by `master`. It accepts framed 32-bit words one bit per `clk` and stores them alternately in two holding buffers. It acknowledges each accepted word with a one-cycle `Ackout` pulse for the transmitter's `Ackrecvd` input, and lets a local reader pop words in arrival order.

---
 rtl/slave_rx.sv | 147 ++++++++++++++
 tb/tb_slave_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/slave_rx.sv
// slave_rx: double-buffered serial frame receiver with per-word Ackout pulse.
// Optional trailing even-parity bit enabled by defining SLAVE_RX_PARITY_EN.
module slave_rx #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RXin,
  input  logic              read,
  output logic              Ackout,
  output logic [DATA_W-1:0] RXOut,
  output logic              RXValid,
  output logic              RXBuff0,
  output logic              RXBuff1,
  output logic              Overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

`ifdef SLAVE_RX_PARITY_EN
  localparam int SW = DATA_W;
`else
  // Without parity the final bit is taken straight from RXin, so one fewer register bit.
  localparam int SW = DATA_W - 1;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_shift;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic              r_wp;
  logic              r_rp;
  logic              r_ack;
  logic              r_ovr;

  logic              w_rd_fire;
  logic              w_last_data;
  logic              w_end;
  logic              w_par_ok;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_drop_ovr;
  logic [DATA_W-1:0] w_frame;

  assign w_rd_fire   = read & r_full[r_rp];
  assign w_last_data = (r_state == S_DATA) && (r_cnt == LAST_BIT);

`ifdef SLAVE_RX_PARITY_EN
  assign w_end    = (r_state == S_PARITY);
  assign w_frame  = r_shift;
  assign w_par_ok = ~(^r_shift ^ RXin);
`else
  assign w_end    = w_last_data;
  assign w_frame  = {r_shift, RXin};
  assign w_par_ok = 1'b1;
`endif

  // A read on the commit edge frees the slot being written when both are full.
  assign w_slot_free = ~r_full[r_wp] | (w_rd_fire & (r_rp == r_wp));
  assign w_accept    = w_end & w_par_ok & w_slot_free;
  assign w_drop_ovr  = w_end & w_par_ok & ~w_slot_free;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!RXin) w_state_nxt = S_DATA;
      S_DATA: begin
        if (r_cnt == LAST_BIT) begin
`ifdef SLAVE_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_ACK;
`endif
        end
      end
      S_PARITY: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_fire) w_full_nxt[r_rp] = 1'b0;
    if (w_accept)  w_full_nxt[r_wp] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (r_state == S_DATA) begin
        r_cnt <= r_cnt + 1'b1;
`ifdef SLAVE_RX_PARITY_EN
        r_shift <= {r_shift[SW-2:0], RXin};
`else
        r_shift <= w_frame[SW-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_full <= '0;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_ack  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_ack  <= w_accept;
      if (w_accept) begin
        if (r_wp) r_buf1 <= w_frame;
        else      r_buf0 <= w_frame;
        r_wp <= ~r_wp;
      end
      if (w_rd_fire)  r_rp  <= ~r_rp;
      if (w_drop_ovr) r_ovr <= 1'b1;
    end
  end

  assign Ackout  = r_ack;
  assign RXOut   = r_rp ? r_buf1 : r_buf0;
  assign RXValid = r_full[r_rp];
  assign RXBuff0 = r_full[0];
  assign RXBuff1 = r_full[1];
  assign Overrun = r_ovr;

endmodule

// File: tb/tb_slave_rx.sv
// Scoreboard bench for slave_rx: expected acks and popped words are queued by the
// stimulus and checked by an independent monitor on the falling edge.
`timescale 1ns/1ps
module tb_slave_rx;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         RXin = 1'b1;
  logic         read = 1'b0;
  logic         Ackout;
  logic [W-1:0] RXOut;
  logic         RXValid;
  logic         RXBuff0;
  logic         RXBuff1;
  logic         Overrun;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] q_ack[$];
  logic [W-1:0] q_rd[$];
  logic         prev_ack = 1'b0;

  slave_rx #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .RXin(RXin), .read(read),
    .Ackout(Ackout), .RXOut(RXOut), .RXValid(RXValid),
    .RXBuff0(RXBuff0), .RXBuff1(RXBuff1), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Ackout must match a queued acceptance, every pop a queued word.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (Ackout) begin
        check("ack_one_cycle", W'(prev_ack), '0);
        check("ack_expected", W'(q_ack.size() != 0), W'(1));
        if (q_ack.size() != 0) void'(q_ack.pop_front());
      end
      if (read && RXValid) begin
        check("pop_expected", W'(q_rd.size() != 0), W'(1));
        if (q_rd.size() != 0) check("pop_word", RXOut, q_rd.pop_front());
      end
    end
    prev_ack = Ackout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic send(input logic [W-1:0] word, input bit rd_at_commit, input bit par_flip);
    @(posedge clk); #1 RXin = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      @(posedge clk); #1 RXin = word[i];
`ifndef SLAVE_RX_PARITY_EN
      if (i == 0 && rd_at_commit) read = 1'b1;
`endif
    end
`ifdef SLAVE_RX_PARITY_EN
    @(posedge clk); #1 RXin = (^word) ^ par_flip;
    read = rd_at_commit;
`else
    if (par_flip) RXin = 1'b1;
`endif
    @(posedge clk); #1 RXin = 1'b1;
    read = 1'b0;
  endtask

  task automatic pop();
    @(posedge clk); #1 read = 1'b1;
    @(posedge clk); #1 read = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_Ackout"}, W'(Ackout), '0);
    check({tag, "_RXValid"}, W'(RXValid), '0);
    check({tag, "_RXBuff0"}, W'(RXBuff0), '0);
    check({tag, "_RXBuff1"}, W'(RXBuff1), '0);
    check({tag, "_Overrun"}, W'(Overrun), '0);
    check({tag, "_RXOut"}, RXOut, '0);
  endtask

  initial begin
    logic [W-1:0] partial;
    partial = 32'hFFF0_0000;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single word
    q_ack.push_back(32'd2); q_rd.push_back(32'd2);
    send(32'd2, 0, 0);
    check("w2_buff0", W'(RXBuff0), W'(1));
    check("w2_valid", W'(RXValid), W'(1));
    check("w2_out", RXOut, 32'd2);
    check("w2_buff1", W'(RXBuff1), '0);
    pop();
    check("w2_empty", W'(RXValid), '0);

    // Two back-to-back words, in-order pops
    q_ack.push_back(32'd8); q_rd.push_back(32'd8);
    q_ack.push_back(32'd67); q_rd.push_back(32'd67);
    send(32'd8, 0, 0);
    send(32'd67, 0, 0);
    check("bb_buff0", W'(RXBuff0), W'(1));
    check("bb_buff1", W'(RXBuff1), W'(1));
    check("bb_out", RXOut, 32'd8);
    pop();
    check("bb_out2", RXOut, 32'd67);
    pop();
    check("bb_empty", W'(RXValid), '0);

    // Both full, read lands on the commit edge of 9
    q_ack.push_back(32'd8); q_rd.push_back(32'd8);
    q_ack.push_back(32'd67); q_rd.push_back(32'd67);
    send(32'd8, 0, 0);
    send(32'd67, 0, 0);
    q_ack.push_back(32'd9); q_rd.push_back(32'd9);
    send(32'd9, 1, 0);
    check("rc_overrun", W'(Overrun), '0);
    check("rc_buff0", W'(RXBuff0), W'(1));
    check("rc_buff1", W'(RXBuff1), W'(1));
    check("rc_out", RXOut, 32'd67);
    pop();
    pop();
    check("rc_empty", W'(RXValid), '0);

    // Overrun: third word dropped
    q_ack.push_back(32'd8); q_rd.push_back(32'd8);
    q_ack.push_back(32'd67); q_rd.push_back(32'd67);
    send(32'd8, 0, 0);
    send(32'd67, 0, 0);
    send(32'd5, 0, 0);
    check("ov_flag", W'(Overrun), W'(1));
    check("ov_out", RXOut, 32'd8);
    pop();
    pop();
    check("ov_empty", W'(RXValid), '0);
    check("ov_sticky", W'(Overrun), W'(1));

    // Reset in the middle of a frame, with a word still held
    q_ack.push_back(32'h4D);
    send(32'h4D, 0, 0);
    check("pre_rst_valid", W'(RXValid), W'(1));
    @(posedge clk); #1 RXin = 1'b0;
    for (int i = W - 1; i >= W - 12; i--) begin
      @(posedge clk); #1 RXin = partial[i];
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    RXin = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    q_ack.push_back(32'hA5A5A5A5); q_rd.push_back(32'hA5A5A5A5);
    send(32'hA5A5A5A5, 0, 0);
    check("a5_buff0", W'(RXBuff0), W'(1));
    check("a5_buff1", W'(RXBuff1), '0);
    check("a5_out", RXOut, 32'hA5A5A5A5);
    pop();
    check("a5_empty", W'(RXValid), '0);

`ifdef SLAVE_RX_PARITY_EN
    q_ack.push_back(32'd3); q_rd.push_back(32'd3);
    send(32'd3, 0, 0);
    check("par_ok_buff1", W'(RXBuff1), W'(1));
    check("par_ok_out", RXOut, 32'd3);
    send(32'd3, 0, 1);
    check("par_bad_buff0", W'(RXBuff0), '0);
    check("par_bad_buff1", W'(RXBuff1), W'(1));
    check("par_bad_overrun", W'(Overrun), '0);
    pop();
    check("par_empty", W'(RXValid), '0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("ack_queue_drained", W'(q_ack.size()), '0);
    check("rd_queue_drained", W'(q_rd.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
